// File: rtl/bl_pkg.sv
// rtl/bl_pkg.sv - shared types and constants for the backlight statistics path
package bl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        MIX,
        OUT
    } bl_state_t;

    localparam int BL_W       = 8;
    localparam int DIV_STEPS  = 8;
    localparam int DEF_MAX_WT = 8;
    localparam int DEF_BL_MIN = 0;

endpackage

// File: rtl/y_frame_stats_if.sv
// rtl/y_frame_stats_if.sv - pixel input and per-frame result bundle for y_frame_stats
interface y_frame_stats_if;
    import bl_pkg::*;

    logic            iDE;
    logic [7:0]      iY;
    logic [BL_W-1:0] oMAX;
    logic [BL_W-1:0] oMEAN;
    logic [BL_W-1:0] oBL;
    logic            oBL_VALID;
    logic            oBUSY;
    logic            oDROP;

    modport master (
        output iDE, iY,
        input  oMAX, oMEAN, oBL, oBL_VALID, oBUSY, oDROP
    );

    modport slave (
        input  iDE, iY,
        output oMAX, oMEAN, oBL, oBL_VALID, oBUSY, oDROP
    );

endinterface

// File: rtl/y_mean_div.sv
// rtl/y_mean_div.sv - serial restoring divider producing an 8-bit frame mean
module y_mean_div
    import bl_pkg::*;
#(
    parameter int SUM_W = 32,
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [BL_W-1:0]  quotient
);

    localparam int KW = $clog2(DIV_STEPS);
    localparam int AW = (SUM_W > CNT_W + DIV_STEPS) ? SUM_W : CNT_W + DIV_STEPS;

    logic [AW-1:0]    rem;
    logic [AW-1:0]    shifted;
    logic [CNT_W-1:0] dvs;
    logic [KW-1:0]    k;
    logic             run;

    assign shifted = AW'(dvs) << k;
    // done coincides with the final step, so the quotient is complete on the next cycle
    assign done    = run && (k == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem      <= '0;
            dvs      <= '0;
            k        <= '0;
            run      <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= AW'(dividend);
            dvs      <= divisor;
            k        <= KW'(DIV_STEPS - 1);
            run      <= 1'b1;
            quotient <= '0;
        end else if (run) begin
            if (rem >= shifted) begin
                rem         <= rem - shifted;
                quotient[k] <= 1'b1;
            end
            if (k == '0) begin
                run <= 1'b0;
            end else begin
                k <= k - KW'(1);
            end
        end
    end

endmodule

// File: rtl/y_frame_stats.sv
// rtl/y_frame_stats.sv - per-frame luma peak/mean statistics and backlight level blend
module y_frame_stats
    import bl_pkg::*;
#(
    parameter int V_ACTIVE = 1080,
    parameter int SUM_W    = 32,
    parameter int CNT_W    = 22,
    parameter int MAX_WT   = DEF_MAX_WT,
    parameter int BL_MIN   = DEF_BL_MIN
) (
    input logic             iODCK,
    input logic             iRST_N,
    y_frame_stats_if.slave  bus
);

    localparam int LW = $clog2(V_ACTIVE + 1);

    logic             de_d;
    logic [SUM_W-1:0] sum_acc;
    logic [CNT_W-1:0] cnt_acc;
    logic [BL_W-1:0]  max_acc;
    logic [BL_W-1:0]  max_snap;
    logic [LW-1:0]    line_cnt;
    bl_state_t        state;

    logic             line_end;
    logic             frame_end;
    logic             div_start;
    logic             div_done;
    logic [BL_W-1:0]  quot;
    logic [12:0]      blend;
    logic [BL_W-1:0]  bl_clamped;

    assign line_end  = de_d && !bus.iDE;
    assign frame_end = line_end && (line_cnt == LW'(V_ACTIVE - 1));
    assign div_start = frame_end && (state == IDLE);

    assign blend      = (13'(MAX_WT) * 13'(max_snap) + 13'(16 - MAX_WT) * 13'(quot) + 13'd8) >> 4;
    assign bl_clamped = (blend < 13'(BL_MIN)) ? BL_W'(BL_MIN) : blend[BL_W-1:0];

    // The divider samples the live accumulators on the frame-end edge, which also clears them
    y_mean_div #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (iODCK),
        .resetn   (iRST_N),
        .start    (div_start),
        .dividend (sum_acc),
        .divisor  (cnt_acc),
        .done     (div_done),
        .quotient (quot)
    );

    always_ff @(posedge iODCK) begin
        if (!iRST_N) begin
            de_d          <= 1'b0;
            sum_acc       <= '0;
            cnt_acc       <= '0;
            max_acc       <= '0;
            max_snap      <= '0;
            line_cnt      <= '0;
            state         <= IDLE;
            bus.oMAX      <= '0;
            bus.oMEAN     <= '0;
            bus.oBL       <= '0;
            bus.oBL_VALID <= 1'b0;
            bus.oBUSY     <= 1'b0;
            bus.oDROP     <= 1'b0;
        end else begin
            de_d <= bus.iDE;

            if (frame_end) begin
                sum_acc  <= '0;
                cnt_acc  <= '0;
                max_acc  <= '0;
                line_cnt <= '0;
                if (state == IDLE) begin
                    max_snap <= max_acc;
                end else begin
                    bus.oDROP <= 1'b1;
                end
            end else begin
                if (line_end) begin
                    line_cnt <= line_cnt + LW'(1);
                end
                if (bus.iDE) begin
                    sum_acc <= sum_acc + SUM_W'(bus.iY);
                    cnt_acc <= cnt_acc + CNT_W'(1);
                    if (bus.iY > max_acc) begin
                        max_acc <= bus.iY;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (frame_end) begin
                        state     <= DIV;
                        bus.oBUSY <= 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state <= MIX;
                    end
                end
                MIX: begin
                    bus.oMAX      <= max_snap;
                    bus.oMEAN     <= quot;
                    bus.oBL       <= bl_clamped;
                    bus.oBL_VALID <= 1'b1;
                    bus.oBUSY     <= 1'b0;
                    state         <= OUT;
                end
                OUT: begin
                    bus.oBL_VALID <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y_frame_stats.sv
// tb/tb_y_frame_stats.sv - scoreboard bench for y_frame_stats across three configurations
module tb_y_frame_stats;

    typedef struct {
        int mx;
        int mn;
        int bl;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         pass = 0;

    logic       rst_n [3];
    logic       de_s  [3];
    logic [7:0] y_s   [3];
    logic [7:0] mx_o  [3];
    logic [7:0] mn_o  [3];
    logic [7:0] bl_o  [3];
    logic       vld_o [3];
    logic       busy_o[3];
    logic       drop_o[3];

    exp_t exp_q[3][$];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut 0: V_ACTIVE=2, BL_MIN=0; dut 1: V_ACTIVE=2, BL_MIN=16; dut 2: V_ACTIVE=1, BL_MIN=0
    for (genvar g = 0; g < 3; g++) begin : u
        y_frame_stats_if ifc ();

        y_frame_stats #(
            .V_ACTIVE ((g == 2) ? 1 : 2),
            .SUM_W    (32),
            .CNT_W    (22),
            .MAX_WT   (8),
            .BL_MIN   ((g == 1) ? 16 : 0)
        ) dut (
            .iODCK  (clk),
            .iRST_N (rst_n[g]),
            .bus    (ifc)
        );

        assign ifc.iDE   = de_s[g];
        assign ifc.iY    = y_s[g];
        assign mx_o[g]   = ifc.oMAX;
        assign mn_o[g]   = ifc.oMEAN;
        assign bl_o[g]   = ifc.oBL;
        assign vld_o[g]  = ifc.oBL_VALID;
        assign busy_o[g] = ifc.oBUSY;
        assign drop_o[g] = ifc.oDROP;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int idx, input int n, input int yf, input int yr);
        for (int i = 0; i < n; i++) begin
            de_s[idx] = 1'b1;
            y_s[idx]  = (i == 0) ? 8'(yf) : 8'(yr);
            tick();
        end
        de_s[idx] = 1'b0;
        y_s[idx]  = 8'd0;
    endtask

    // Called in the frame-end cycle: the pulse is due ten cycles later
    task automatic push(input int idx, input int mx, input int mn, input int bl);
        exp_t e;
        e.mx  = mx;
        e.mn  = mn;
        e.bl  = bl;
        e.cyc = cyc + 10;
        exp_q[idx].push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (vld_o[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("unexpected_pulse_dut%0d", i), 1, 0);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("max_dut%0d", i), int'(mx_o[i]), e.mx);
                    check($sformatf("mean_dut%0d", i), int'(mn_o[i]), e.mn);
                    check($sformatf("bl_dut%0d", i), int'(bl_o[i]), e.bl);
                    check($sformatf("latency_dut%0d", i), cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            de_s[i]  = 1'b0;
            y_s[i]   = 8'd0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_max_dut%0d", i), int'(mx_o[i]), 0);
            check($sformatf("rst_mean_dut%0d", i), int'(mn_o[i]), 0);
            check($sformatf("rst_bl_dut%0d", i), int'(bl_o[i]), 0);
            check($sformatf("rst_valid_dut%0d", i), int'(vld_o[i]), 0);
            check($sformatf("rst_busy_dut%0d", i), int'(busy_o[i]), 0);
            check($sformatf("rst_drop_dut%0d", i), int'(drop_o[i]), 0);
            rst_n[i] = 1'b1;
        end
        tick();

        // flat frame, also probes busy mid-division
        line(0, 4, 100, 100);
        tick();
        line(0, 4, 100, 100);
        push(0, 100, 100, 100);
        repeat (5) tick();
        check("busy_in_div", int'(busy_o[0]), 1);
        repeat (8) tick();
        check("busy_after_out", int'(busy_o[0]), 0);

        // single bright pixel
        line(0, 4, 255, 0);
        tick();
        line(0, 4, 0, 0);
        push(0, 255, 31, 143);
        repeat (12) tick();

        // unequal line lengths
        line(0, 3, 10, 10);
        tick();
        line(0, 5, 20, 20);
        push(0, 20, 16, 18);
        repeat (12) tick();

        // reset in the middle of line 2, then a clean frame
        line(0, 3, 90, 90);
        tick();
        de_s[0] = 1'b1;
        y_s[0]  = 8'd90;
        repeat (2) tick();
        rst_n[0] = 1'b0;
        repeat (2) tick();
        rst_n[0] = 1'b1;
        de_s[0]  = 1'b0;
        y_s[0]   = 8'd0;
        check("midrst_max", int'(mx_o[0]), 0);
        check("midrst_mean", int'(mn_o[0]), 0);
        check("midrst_bl", int'(bl_o[0]), 0);
        tick();
        line(0, 4, 50, 50);
        tick();
        line(0, 4, 50, 50);
        push(0, 50, 50, 50);
        repeat (9) tick();
        check("prepulse_bl", int'(bl_o[0]), 0);
        check("prepulse_max", int'(mx_o[0]), 0);
        repeat (4) tick();

        // BL_MIN clamp, then a back-to-back frame while the first is still in flight
        line(1, 4, 0, 0);
        tick();
        line(1, 4, 0, 0);
        push(1, 0, 0, 16);
        tick();
        line(1, 5, 200, 200);
        tick();
        line(1, 5, 200, 200);
        push(1, 200, 200, 200);
        repeat (12) tick();
        check("drop_dut1", int'(drop_o[1]), 0);

        // V_ACTIVE=1: second frame ends during division and is dropped
        line(2, 1, 80, 80);
        push(2, 80, 80, 80);
        repeat (3) tick();
        line(2, 1, 200, 200);
        repeat (20) tick();
        check("drop_dut2", int'(drop_o[2]), 1);
        check("drop_dut0", int'(drop_o[0]), 0);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("pending_dut%0d", i), exp_q[i].size(), 0);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
